// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd core input loader.
// Lane index and fill-state types are used by the tile loader.
package wc_pkg;

  localparam int WC_LANES  = 10;
  localparam int WC_DW     = 8;
  localparam int WC_DBUS_W = WC_LANES * WC_DW;

  typedef logic [3:0] wc_lane_t;

  typedef enum logic {
    WC_FILL = 1'b0,
    WC_FULL = 1'b1
  } wc_fill_state_t;

endpackage

// File: rtl/wc_tile_loader.sv
// Byte-serial to 80-bit tile packer with a double-buffered shadow/output pair.
//   state   | meaning
//   WC_FILL | shadow accepting bytes, lane_q is the next lane to write
//   WC_FULL | shadow holds a complete tile waiting for the output slot
module wc_tile_loader
  import wc_pkg::*;
#(
  parameter int LANES = WC_LANES,
  parameter int DW    = WC_DW,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [LANES*DW-1:0]   D,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  resync,
  output logic [CNT_W-1:0]      tile_cnt
);

  localparam wc_lane_t LAST_LANE = wc_lane_t'(LANES - 1);

  wc_fill_state_t        state_q, state_d;
  wc_lane_t              lane_q, lane_d;
  logic [LANES*DW-1:0]   shadow_q, shadow_d;
  logic [LANES*DW-1:0]   d_q, d_d;
  logic                  d_valid_q, d_valid_d;
  logic                  resync_q, resync_d;
  logic [CNT_W-1:0]      tile_cnt_q, tile_cnt_d;

  logic     shadow_full;
  logic     accept;
  logic     transfer;
  logic     deliver;
  logic     sof_restart;
  wc_lane_t wr_lane;

  assign shadow_full = (state_q == WC_FULL);
  assign in_ready    = !shadow_full;
  assign accept      = in_valid && in_ready;
  assign transfer    = shadow_full && (!d_valid_q || d_ready);
  assign deliver     = d_valid_q && d_ready;
  // A start marker mid-tile restarts the tile at lane 0; stale lanes get overwritten.
  assign sof_restart = accept && in_sof && (lane_q != '0);
  assign wr_lane     = sof_restart ? '0 : lane_q;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    shadow_d   = shadow_q;
    d_d        = d_q;
    d_valid_d  = d_valid_q;
    resync_d   = sof_restart;
    tile_cnt_d = tile_cnt_q + {{(CNT_W-1){1'b0}}, deliver};

    case (state_q)
      WC_FILL: begin
        if (accept) begin
          shadow_d[wr_lane*DW +: DW] = in_data;
          if (wr_lane == LAST_LANE) begin
            state_d = WC_FULL;
            lane_d  = '0;
          end else begin
            lane_d = wr_lane + wc_lane_t'(1);
          end
        end
      end
      WC_FULL: begin
        if (transfer) begin
          d_d       = shadow_q;
          d_valid_d = 1'b1;
          state_d   = WC_FILL;
        end
      end
      default: state_d = WC_FILL;
    endcase

    // A delivery coinciding with a transfer keeps d_valid high for the new tile.
    if (deliver && !transfer) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WC_FILL;
      lane_q     <= '0;
      shadow_q   <= '0;
      d_q        <= '0;
      d_valid_q  <= 1'b0;
      resync_q   <= 1'b0;
      tile_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      shadow_q   <= shadow_d;
      d_q        <= d_d;
      d_valid_q  <= d_valid_d;
      resync_q   <= resync_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

  assign D        = d_q;
  assign d_valid  = d_valid_q;
  assign resync   = resync_q;
  assign tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_wc_tile_loader.sv
// Testbench for wc_tile_loader: queue-based reference model with a tile scoreboard,
// a table of tile vectors, and hand sequences for reset, streaming, backpressure, resync, wrap.
module tb_wc_tile_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [79:0] D;
  logic        d_valid;
  logic        d_ready;
  logic        resync;
  logic [15:0] tile_cnt;

  logic        in_ready_w;
  logic [79:0] d_w;
  logic        d_valid_w;
  logic        resync_w;
  logic [3:0]  tile_cnt_w;

  always #5 clk = ~clk;

  wc_tile_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .D(D), .d_valid(d_valid), .d_ready(d_ready),
    .resync(resync), .tile_cnt(tile_cnt)
  );

  // Narrow-counter instance so the counter wrap is reachable in a few hundred cycles.
  wc_tile_loader #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready_w), .D(d_w), .d_valid(d_valid_w), .d_ready(d_ready),
    .resync(resync_w), .tile_cnt(tile_cnt_w)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stalls = 0;
  int rs_count = 0;
  int dl_cyc[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model
  logic [7:0]  m_bytes[$];
  logic [79:0] sb[$];
  logic [79:0] m_shadow, m_d;
  logic        m_full, m_dvalid, m_resync;
  logic [15:0] m_cnt;

  always @(negedge clk) begin
    logic acc, xfer, dlv, n_rs;
    logic [79:0] exp_t;
    cyc++;
    if (rst) begin
      m_bytes.delete(); sb.delete();
      m_shadow = '0; m_d = '0; m_full = 0; m_dvalid = 0; m_resync = 0; m_cnt = '0;
    end
    chk("in_ready", {79'd0, in_ready}, {79'd0, !m_full});
    chk("d_valid", {79'd0, d_valid}, {79'd0, m_dvalid});
    chk("D", D, m_d);
    chk("resync", {79'd0, resync}, {79'd0, m_resync});
    chk("tile_cnt", {64'd0, tile_cnt}, {64'd0, m_cnt});
    chk("tile_cnt_w", {76'd0, tile_cnt_w}, {76'd0, m_cnt[3:0]});
    chk("d_valid_w", {79'd0, d_valid_w}, {79'd0, m_dvalid});
    if (resync) rs_count++;
    if (d_valid && d_ready) dl_cyc.push_back(cyc);
    if (!rst) begin
      acc  = in_valid && !m_full;
      xfer = m_full && (!m_dvalid || d_ready);
      dlv  = m_dvalid && d_ready;
      n_rs = 1'b0;
      if (dlv) begin
        m_cnt++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_empty: delivery with no expected tile (cycle %0d)", cyc);
        end else begin
          exp_t = sb.pop_front();
          chk("sb_tile", D, exp_t);
        end
      end
      if (xfer) begin
        m_d = m_shadow; m_dvalid = 1'b1; m_full = 1'b0;
      end else if (dlv) begin
        m_dvalid = 1'b0;
      end
      if (acc) begin
        if (in_sof && m_bytes.size() != 0) begin
          m_bytes.delete();
          n_rs = 1'b1;
        end
        m_bytes.push_back(in_data);
        if (m_bytes.size() == 10) begin
          for (int k = 0; k < 10; k++) m_shadow[k*8 +: 8] = m_bytes[k];
          m_full = 1'b1;
          sb.push_back(m_shadow);
          m_bytes.delete();
        end
      end
      m_resync = n_rs;
    end
  end

  task automatic send(input logic [7:0] b, input logic sof);
    int guard;
    guard = 0;
    in_data = b; in_valid = 1'b1; in_sof = sof;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      stalls++;
      guard++;
      if (guard > 100) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: in_ready stuck low, byte %h", b);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          pre_n;
    logic [7:0]  base;
    logic [79:0] exp_d;
    int          exp_rs;
  } vec_t;

  vec_t vecs[4];

  localparam logic [79:0] BP_T1 = 80'h49484746454443424140;
  localparam logic [79:0] BP_T2 = 80'h535251504F4E4D4C4B4A;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rs0;
    vecs[0] = '{0, 8'h30, 80'h39383736353433323130, 0};
    vecs[1] = '{3, 8'hF8, 80'h0100FFFEFDFCFBFAF9F8, 1};
    vecs[2] = '{9, 8'h60, 80'h69686766656463626160, 1};
    vecs[3] = '{0, 8'hC0, 80'hC9C8C7C6C5C4C3C2C1C0, 0};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; d_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", {79'd0, d_valid}, 80'd0);
    chk("rst_D", D, 80'd0);
    chk("rst_tile_cnt", {64'd0, tile_cnt}, 80'd0);
    chk("rst_in_ready", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Reset mid-tile after one delivered tile
    for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i), 1'b0);
    idle(2);
    chk("pre_rst_cnt", {64'd0, tile_cnt}, 80'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_d_valid", {79'd0, d_valid}, 80'd0);
    chk("mid_rst_cnt", {64'd0, tile_cnt}, 80'd0);
    chk("mid_rst_in_ready", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
    idle(3);
    chk("post_rst_D", D, 80'h09080706050403020100);

    // Streaming
    pulse_reset();
    stalls = 0;
    dl_cyc.delete();
    for (int i = 0; i < 30; i++) send(8'h10 + 8'(i), 1'b0);
    chk("stream_stalls", 80'(stalls), 80'd2);
    idle(3);
    chk("stream_tiles", 80'(dl_cyc.size()), 80'd3);
    if (dl_cyc.size() == 3) begin
      chk("stream_gap1", 80'(dl_cyc[1] - dl_cyc[0]), 80'd11);
      chk("stream_gap2", 80'(dl_cyc[2] - dl_cyc[1]), 80'd11);
    end
    chk("stream_cnt", {64'd0, tile_cnt}, 80'd3);
    chk("stream_D", D, 80'h2D2C2B2A292827262524);

    // Backpressure
    d_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(8'h40 + 8'(i), 1'b0);
    @(negedge clk);
    chk("bp_d_valid", {79'd0, d_valid}, 80'd1);
    chk("bp_D", D, BP_T1);
    chk("bp_in_ready", {79'd0, in_ready}, 80'd0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_D", D, BP_T1);
      chk("bp_hold_in_ready", {79'd0, in_ready}, 80'd0);
    end
    chk("bp_cnt", {64'd0, tile_cnt}, 80'd3);
    @(posedge clk); #1 d_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_xfer_d_valid", {79'd0, d_valid}, 80'd1);
    chk("bp_xfer_D", D, BP_T2);
    chk("bp_xfer_cnt", {64'd0, tile_cnt}, 80'd4);
    @(negedge clk);
    chk("bp_drain_d_valid", {79'd0, d_valid}, 80'd0);
    chk("bp_drain_cnt", {64'd0, tile_cnt}, 80'd5);
    chk("bp_drain_D", D, BP_T2);

    // Resync mid-tile
    rs0 = rs_count;
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0);
    send(8'hAA, 1'b1);
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    idle(3);
    chk("resync_pulses", 80'(rs_count - rs0), 80'd1);
    chk("resync_D", D, 80'h090807060504030201AA);

    // Tile vectors (sof on the first byte of each tile, optional junk prefix)
    foreach (vecs[v]) begin
      rs0 = rs_count;
      for (int i = 0; i < vecs[v].pre_n; i++) send(8'hEE, 1'b0);
      for (int k = 0; k < 10; k++) send(vecs[v].base + 8'(k), k == 0);
      idle(3);
      chk($sformatf("vec%0d_D", v), D, vecs[v].exp_d);
      chk($sformatf("vec%0d_resync", v), 80'(rs_count - rs0), 80'(vecs[v].exp_rs));
    end

    // Counter wrap on the narrow instance
    pulse_reset();
    for (int t = 0; t < 15; t++)
      for (int k = 0; k < 10; k++) send(8'(t * 16 + k), 1'b0);
    idle(3);
    chk("wrap_pre_w", {76'd0, tile_cnt_w}, 80'd15);
    chk("wrap_pre", {64'd0, tile_cnt}, 80'd15);
    for (int k = 0; k < 10; k++) send(8'hF0 + 8'(k), 1'b0);
    idle(3);
    chk("wrap_post_w", {76'd0, tile_cnt_w}, 80'd0);
    chk("wrap_post", {64'd0, tile_cnt}, 80'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
